// File: rtl/stage_accumulator.sv
// -----------------------------------------------------------------------------
// stage_accumulator
//
// Evaluates one cascade stage of a boosted Haar classifier. Database words
// stream in one tree at a time; for each tree the node threshold and the two
// leaf values are captured, the tree's feature value (from the rectangle-sum
// engine) is compared against the node threshold, and the selected leaf
// value is added into a saturating signed accumulator. After the last tree,
// the first trailing word is the stage threshold; the stage passes when the
// accumulator is greater than or equal to it.
//
// Ports
//   clk              single clock
//   reset            asynchronous, active-low reset
//   enable           level; a stage evaluation starts/continues while high
//   i_valid          i_data and its flags are valid this cycle
//   i_data           signed database word
//   i_index_leaf     word position within the current tree
//   i_end_leafs      last word of the current tree
//   i_end_trees      last tree of the stage
//   i_end_database   last word of the stage
//   i_feature_valid  i_feature_value is valid this cycle
//   i_feature_value  signed normalised feature sum for the current tree
//   o_stall          back-pressure; upstream holds its word while high
//   o_tree_count     trees accumulated in the current stage (saturating)
//   o_busy           a stage evaluation is in progress
//   o_done           one-cycle pulse when the stage result is valid
//   o_pass           stage result, held until the next stage starts
// -----------------------------------------------------------------------------
module stage_accumulator #(
  parameter int DATA_WIDTH_16            = 16,
  parameter int DATA_WIDTH_12            = 12,
  parameter int NUM_PARAM_PER_CLASSIFIER = 18,
  parameter int NUM_STAGE_THRESHOLD      = 3,
  parameter int ACC_WIDTH                = 24
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            i_valid,
  input  logic signed [DATA_WIDTH_16-1:0] i_data,
  input  logic        [DATA_WIDTH_12-1:0] i_index_leaf,
  input  logic                            i_end_leafs,
  input  logic                            i_end_trees,
  input  logic                            i_end_database,
  input  logic                            i_feature_valid,
  input  logic signed [DATA_WIDTH_16-1:0] i_feature_value,
  output logic                            o_stall,
  output logic        [DATA_WIDTH_12-1:0] o_tree_count,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_pass
);

  // Positions of the three words of interest inside a tree record.
  localparam logic [DATA_WIDTH_12-1:0] IDX_NODE_THR =
    DATA_WIDTH_12'(NUM_PARAM_PER_CLASSIFIER - 3);
  localparam logic [DATA_WIDTH_12-1:0] IDX_LEFT =
    DATA_WIDTH_12'(NUM_PARAM_PER_CLASSIFIER - 2);
  localparam logic [DATA_WIDTH_12-1:0] IDX_RIGHT =
    DATA_WIDTH_12'(NUM_PARAM_PER_CLASSIFIER - 1);

  // Trailing-word counter only needs to tell "first word" from the rest;
  // it saturates at the number of trailing words.
  localparam int                     THR_CNT_W   = $clog2(NUM_STAGE_THRESHOLD + 1);
  localparam logic [THR_CNT_W-1:0]   THR_CNT_MAX = THR_CNT_W'(NUM_STAGE_THRESHOLD);

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WAIT_FEAT,
    ACCUM,
    THRESH,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic signed [ACC_WIDTH-1:0]     acc;
  logic signed [ACC_WIDTH-1:0]     stage_thr;
  logic signed [ACC_WIDTH-1:0]     add_val;
  logic signed [ACC_WIDTH-1:0]     cmp_thr;
  logic signed [DATA_WIDTH_16-1:0] node_thr;
  logic signed [DATA_WIDTH_16-1:0] left_val;
  logic signed [DATA_WIDTH_16-1:0] right_val;
  logic signed [DATA_WIDTH_16-1:0] feat_p0;
  logic                            vld_p0;
  logic                            last_tree;
  logic        [THR_CNT_W-1:0]     thr_cnt;

  logic consume;
  logic abort;
  logic feat_take;
  logic feat_ready;
  logic pass_cmp;

  // Sign-extend a database word to the accumulator width.
  function automatic logic signed [ACC_WIDTH-1:0] sext(
    input logic signed [DATA_WIDTH_16-1:0] v
  );
    return ACC_WIDTH'(v);
  endfunction

  // Signed add clamped to the accumulator range. One guard bit exposes
  // overflow: guard and MSB disagree exactly when the true sum is out of range.
  function automatic logic signed [ACC_WIDTH-1:0] sat_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
    logic signed [ACC_WIDTH:0] sum;
    sum = (ACC_WIDTH+1)'(a) + (ACC_WIDTH+1)'(b);
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
      return sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
    return sum[ACC_WIDTH-1:0];
  endfunction

  // Unsigned increment that sticks at all-ones.
  function automatic logic [DATA_WIDTH_12-1:0] sat_inc(
    input logic [DATA_WIDTH_12-1:0] c
  );
    return (&c) ? c : c + 1'b1;
  endfunction

  assign o_busy  = (state != IDLE);
  assign o_done  = (state == DONE);
  assign o_stall = (state == WAIT_FEAT) || (state == ACCUM) || (state == DONE);

  assign consume    = i_valid && !o_stall;
  assign abort      = !enable && (state inside {COLLECT, WAIT_FEAT, ACCUM, THRESH});
  // Single-entry feature buffer: a second pulse is dropped while it is full.
  assign feat_take  = i_feature_valid && !vld_p0;
  assign feat_ready = vld_p0 || i_feature_valid;

  assign add_val  = (feat_p0 < node_thr) ? sext(left_val) : sext(right_val);
  // When the end-of-stage flag rides on the threshold word itself, compare
  // against the incoming word rather than the not-yet-written register.
  assign cmp_thr  = (thr_cnt == '0) ? sext(i_data) : stage_thr;
  assign pass_cmp = (acc >= cmp_thr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable) state_nxt = COLLECT;
      end
      COLLECT: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (consume && i_end_database) begin
          state_nxt = DONE;
        end else if (consume && i_end_leafs) begin
          // A feature already buffered (or arriving now) skips WAIT_FEAT.
          state_nxt = feat_ready ? ACCUM : WAIT_FEAT;
        end
      end
      WAIT_FEAT: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (feat_ready) begin
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = last_tree ? THRESH : COLLECT;
        end
      end
      THRESH: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (consume && i_end_database) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc          <= '0;
      stage_thr    <= '0;
      node_thr     <= '0;
      left_val     <= '0;
      right_val    <= '0;
      feat_p0      <= '0;
      vld_p0       <= 1'b0;
      last_tree    <= 1'b0;
      thr_cnt      <= '0;
      o_tree_count <= '0;
      o_pass       <= 1'b0;
    end else if (abort) begin
      o_pass <= 1'b0;
      vld_p0 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            acc          <= '0;
            o_tree_count <= '0;
            o_pass       <= 1'b0;
            vld_p0       <= 1'b0;
            last_tree    <= 1'b0;
            thr_cnt      <= '0;
          end
        end
        // Tree words: capture threshold/leaves, remember end-of-trees flag.
        COLLECT: begin
          if (feat_take) begin
            feat_p0 <= i_feature_value;
            vld_p0  <= 1'b1;
          end
          if (consume) begin
            last_tree <= i_end_trees;
            if (i_index_leaf == IDX_NODE_THR) begin
              node_thr <= i_data;
            end else if (i_index_leaf == IDX_LEFT) begin
              left_val <= i_data;
            end else if (i_index_leaf == IDX_RIGHT) begin
              right_val <= i_data;
            end
            // Truncated stage: no threshold was seen, so it cannot pass.
            if (i_end_database) o_pass <= 1'b0;
          end
        end
        WAIT_FEAT: begin
          if (feat_take) begin
            feat_p0 <= i_feature_value;
            vld_p0  <= 1'b1;
          end
        end
        // Accumulate the selected leaf and release the feature buffer.
        ACCUM: begin
          acc          <= sat_add(acc, add_val);
          o_tree_count <= sat_inc(o_tree_count);
          vld_p0       <= 1'b0;
        end
        // Trailing words: first is the stage threshold, the rest are dropped.
        THRESH: begin
          if (consume) begin
            if (thr_cnt == '0) stage_thr <= sext(i_data);
            if (thr_cnt != THR_CNT_MAX) thr_cnt <= thr_cnt + 1'b1;
            if (i_end_database) o_pass <= pass_cmp;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
